// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared frame states, parity selectors and line levels for the UART TX path.
package uart_tx_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;
    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: byte handshake, serializer link and TX line between the frame controller and its neighbours.
interface uart_tx_ctrl_if #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic                  ser_data;
    logic                  ser_done;
    logic                  ser_en;
    logic                  busy;
    logic                  tx_out;
    modport master (
        output p_data, data_valid, par_en, par_typ, ser_data, ser_done,
        input  ser_en, busy, tx_out
    );
    modport slave (
        input  p_data, data_valid, par_en, par_typ, ser_data, ser_done,
        output ser_en, busy, tx_out
    );
endinterface

// File: rtl/uart_parity_calc.sv
// uart_parity_calc: XOR-reduce parity of a data word, inverted for odd parity.
module uart_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);
    assign par_bit = (par_typ == PAR_ODD) ? ~^data : ^data;
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: sequences start, data, optional parity and stop bits and muxes the TX line.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_ctrl_if.slave  bus
);
    localparam logic [2:0] S_IDLE   = 3'(IDLE);
    localparam logic [2:0] S_START  = 3'(START);
    localparam logic [2:0] S_DATA   = 3'(DATA);
    localparam logic [2:0] S_PARITY = 3'(PARITY);
    localparam logic [2:0] S_STOP   = 3'(STOP);

    logic [2:0] state;
    logic [2:0] nxt;
    logic       par_en_q;
    logic       par_bit_q;
    logic       par_bit;
    logic       accept;

    uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
        .data    (bus.p_data),
        .par_typ (bus.par_typ),
        .par_bit (par_bit)
    );

    assign accept = (state == S_IDLE) && bus.data_valid;

    // STOP and any unused encoding fall through to IDLE
    always_comb begin
        nxt = (state == S_IDLE)   ? (bus.data_valid ? S_START : S_IDLE) :
              (state == S_START)  ? S_DATA :
              (state == S_DATA)   ? (bus.ser_done ? (par_en_q ? S_PARITY : S_STOP) : S_DATA) :
              (state == S_PARITY) ? S_STOP : S_IDLE;
    end

    // par_typ is folded into the latched parity bit at accept time
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                par_en_q  <= bus.par_en;
                par_bit_q <= par_bit;
            end
        end
    end

    assign bus.busy   = (state == S_START) || (state == S_DATA) ||
                        (state == S_PARITY) || (state == S_STOP);
    assign bus.ser_en = (state == S_DATA);
    assign bus.tx_out = (state == S_START)  ? START_BIT :
                        (state == S_DATA)   ? bus.ser_data :
                        (state == S_PARITY) ? par_bit_q :
                        (state == S_STOP)   ? STOP_BIT : LINE_IDLE;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed frames against hand-computed line patterns, with a behavioural serializer alongside.
module tb_uart_tx_ctrl;
    import uart_tx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    uart_tx_ctrl_if bus ();

    uart_tx_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // serializer: loads on accept, shifts LSB first while ser_en, flags the 8th shift
    logic [7:0] sh;
    logic [3:0] cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh  <= 8'h00;
            cnt <= 4'd0;
        end else if (bus.data_valid && !bus.busy) begin
            sh  <= bus.p_data;
            cnt <= 4'd0;
        end else if (bus.ser_en) begin
            sh  <= sh >> 1;
            cnt <= cnt + 4'd1;
        end
    end
    assign bus.ser_data = sh[0];
    assign bus.ser_done = bus.ser_en && (cnt == 4'd7);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // accept d now, then check n frame cycles against line (cycle 1 = MSB), then the first IDLE cycle
    task automatic frame(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                         input int n, input logic [10:0] line, input logic [11:0] dv_mask, input int pe_at);
        bus.p_data     = d;
        bus.par_en     = pe;
        bus.par_typ    = pt;
        bus.data_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= n; i++) begin
            bus.data_valid = dv_mask[i];
            if (dv_mask[i]) bus.p_data = 8'hFF;
            if (i == pe_at) bus.par_en = 1'b1;
            chk($sformatf("%s_tx%0d", tag, i), 32'(bus.tx_out), 32'(line[n-i]));
            chk($sformatf("%s_busy%0d", tag, i), 32'(bus.busy), 32'd1);
            chk($sformatf("%s_seren%0d", tag, i), 32'(bus.ser_en), 32'((i >= 2 && i <= 9) ? 1 : 0));
            @(posedge clk); #1;
        end
        bus.data_valid = 1'b0;
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_idle_tx"}, 32'(bus.tx_out), 32'd1);
    endtask

    initial begin
        bus.p_data     = 8'h00;
        bus.data_valid = 1'b0;
        bus.par_en     = 1'b0;
        bus.par_typ    = PAR_EVEN;
        #2;
        chk("rst_tx", 32'(bus.tx_out), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_seren", 32'(bus.ser_en), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            chk("idle_tx", 32'(bus.tx_out), 32'd1);
            chk("idle_busy", 32'(bus.busy), 32'd0);
            chk("idle_seren", 32'(bus.ser_en), 32'd0);
            @(posedge clk); #1;
        end

        frame("a5_np", 8'hA5, 1'b0, PAR_EVEN, 10, 11'b00101001011, 12'h000, 0);
        frame("a5_ev", 8'hA5, 1'b1, PAR_EVEN, 11, 11'b01010010101, 12'h000, 0);
        frame("03_od", 8'h03, 1'b1, PAR_ODD, 11, 11'b01100000011, 12'h000, 0);
        frame("01_od", 8'h01, 1'b1, PAR_ODD, 11, 11'b01000000001, 12'h000, 0);

        // requests in cycle 3 and in STOP are dropped; the first IDLE cycle accepts
        frame("3c_drop", 8'h3C, 1'b0, PAR_EVEN, 10, 11'b00001111001, 12'b0100_0000_1000, 0);
        frame("81_b2b", 8'h81, 1'b0, PAR_EVEN, 10, 11'b00100000011, 12'h000, 0);

        // async reset mid-frame
        bus.p_data     = 8'h3C;
        bus.par_en     = 1'b1;
        bus.data_valid = 1'b1;
        @(posedge clk); #1;
        bus.data_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("mid_busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(bus.tx_out), 32'd1);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_seren", 32'(bus.ser_en), 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        frame("81_rst", 8'h81, 1'b0, PAR_EVEN, 10, 11'b00100000011, 12'h000, 0);

        // par_en raised during DATA only affects the following frame
        frame("a5_tog", 8'hA5, 1'b0, PAR_EVEN, 10, 11'b00101001011, 12'h000, 4);
        frame("a5_after", 8'hA5, 1'b1, PAR_EVEN, 11, 11'b01010010101, 12'h000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
